ram_arbiter: RTL and testbench

- Sequences every access to the shared SDRAM-backed byte RAM on behalf of three requesters: the ROM/file loader, the video DMA channel and the CPU.
- Replaces the combinational select in front of the RAM controller with a granted, one-access-at-a-time state machine.
- Returns read data and completion strobes to each requester, and guards against a non-responding memory.
- Sits between the requesters and the sram instance, in the clk_sys domain.

---
 rtl/ram_arbiter_if.sv | 40 ++++
 rtl/ram_arbiter.sv | 122 ++++++++++++
 tb/tb_ram_arbiter.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_arbiter_if.sv
// Requester, RAM-controller and status signals of the shared byte-RAM arbiter.
// master = requesters + RAM controller side, slave = the arbiter itself.
interface ram_arbiter_if;
  logic        ld_req;
  logic [24:0] ld_addr;
  logic [7:0]  ld_data;
  logic        ld_ack;
  logic        dma_req;
  logic [15:0] dma_addr;
  logic        dma_ack;
  logic [7:0]  dma_data;
  logic        cpu_req;
  logic        cpu_we;
  logic [24:0] cpu_addr;
  logic [7:0]  cpu_din;
  logic [7:0]  cpu_dout;
  logic        cpu_ack;
  logic [24:0] mem_addr;
  logic [7:0]  mem_din;
  logic        mem_we;
  logic        mem_rd;
  logic [7:0]  mem_dout;
  logic        mem_ready;
  logic        busy;
  logic        timeout_err;

  modport master (
    output ld_req, ld_addr, ld_data, dma_req, dma_addr,
           cpu_req, cpu_we, cpu_addr, cpu_din, mem_dout, mem_ready,
    input  ld_ack, dma_ack, dma_data, cpu_dout, cpu_ack,
           mem_addr, mem_din, mem_we, mem_rd, busy, timeout_err
  );

  modport slave (
    input  ld_req, ld_addr, ld_data, dma_req, dma_addr,
           cpu_req, cpu_we, cpu_addr, cpu_din, mem_dout, mem_ready,
    output ld_ack, dma_ack, dma_data, cpu_dout, cpu_ack,
           mem_addr, mem_din, mem_we, mem_rd, busy, timeout_err
  );
endinterface

// File: rtl/ram_arbiter.sv
// One-access-at-a-time arbiter in front of the shared byte RAM: loader > DMA > CPU,
// with a DMA run limit protecting the CPU and a WAIT timeout against a dead controller.
module ram_arbiter #(
  parameter int TIMEOUT = 63,
  parameter int DMA_RUN = 4
) (
  input logic         clk_sys,
  input logic         reset,
  ram_arbiter_if.slave bus
);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int RW = $clog2(DMA_RUN + 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;
  typedef enum logic [1:0] {G_NONE, G_LD, G_DMA, G_CPU} gnt_t;

  state_t        r_state, w_next;
  gnt_t          r_gnt, w_gnt;
  logic          r_settle;
  logic [24:0]   r_addr;
  logic [7:0]    r_din;
  logic          r_we;
  logic [TW-1:0] r_tcnt;
  logic [TW-1:0] w_tcnt_inc;
  logic [RW-1:0] r_run;
  logic [7:0]    r_dma_data;
  logic [7:0]    r_cpu_dout;
  logic          r_terr;
  logic          w_tmo;

  // The first IDLE after DONE grants nobody: the previous grantee is still
  // presenting its stale req and must not be served twice.
  always_comb begin
    w_gnt = G_NONE;
    if (!r_settle) begin
      if (bus.ld_req)
        w_gnt = G_LD;
      else if (bus.cpu_req && (!bus.dma_req || r_run == RW'(DMA_RUN)))
        w_gnt = G_CPU;
      else if (bus.dma_req)
        w_gnt = G_DMA;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    w_tcnt_inc = r_tcnt + 1'b1;
    w_tmo      = 1'b0;
    case (r_state)
      S_IDLE:  if (w_gnt != G_NONE) w_next = S_ISSUE;
      S_ISSUE: w_next = S_WAIT;
      S_WAIT: begin
        w_tmo = !bus.mem_ready && (w_tcnt_inc == TW'(TIMEOUT));
        if (bus.mem_ready || w_tmo) w_next = S_DONE;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_gnt      <= G_NONE;
      r_settle   <= 1'b0;
      r_addr     <= '0;
      r_din      <= '0;
      r_we       <= 1'b0;
      r_tcnt     <= '0;
      r_run      <= '0;
      r_dma_data <= '0;
      r_cpu_dout <= '0;
      r_terr     <= 1'b0;
    end else begin
      r_settle <= (r_state == S_DONE);
      case (r_state)
        S_IDLE: begin
          case (w_gnt)
            G_LD:  begin r_addr <= bus.ld_addr;         r_din <= bus.ld_data; r_we <= 1'b1; end
            G_DMA: begin r_addr <= {9'b0, bus.dma_addr}; r_din <= 8'h00;      r_we <= 1'b0; end
            G_CPU: begin r_addr <= bus.cpu_addr;        r_din <= bus.cpu_din; r_we <= bus.cpu_we; end
            default: ;
          endcase
          if (w_gnt != G_NONE) r_gnt <= w_gnt;
        end
        S_WAIT: begin
          r_tcnt <= w_tcnt_inc;
          if (bus.mem_ready || w_tmo) begin
            if (!r_we && r_gnt == G_DMA) r_dma_data <= bus.mem_ready ? bus.mem_dout : 8'hFF;
            if (!r_we && r_gnt == G_CPU) r_cpu_dout <= bus.mem_ready ? bus.mem_dout : 8'hFF;
          end
          if (w_tmo) r_terr <= 1'b1;
        end
        S_DONE:  r_tcnt <= '0;
        default: ;
      endcase
      // run of DMA grants made while the CPU waits; saturates at the limit
      if (!bus.cpu_req)
        r_run <= '0;
      else if (r_state == S_IDLE && w_gnt == G_CPU)
        r_run <= '0;
      else if (r_state == S_IDLE && w_gnt == G_DMA && r_run != RW'(DMA_RUN))
        r_run <= r_run + 1'b1;
    end
  end

  assign bus.mem_addr    = r_addr;
  assign bus.mem_din     = r_din;
  assign bus.mem_we      = (r_state == S_ISSUE) &&  r_we;
  assign bus.mem_rd      = (r_state == S_ISSUE) && !r_we;
  assign bus.ld_ack      = (r_state == S_DONE) && (r_gnt == G_LD);
  assign bus.dma_ack     = (r_state == S_DONE) && (r_gnt == G_DMA);
  assign bus.cpu_ack     = (r_state == S_DONE) && (r_gnt == G_CPU);
  assign bus.dma_data    = r_dma_data;
  assign bus.cpu_dout    = r_cpu_dout;
  assign bus.busy        = (r_state != S_IDLE);
  assign bus.timeout_err = r_terr;
endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: table of single accesses plus priority, run-limit,
// timeout and reset sequences, all scored against expected access/ack queues.
module tb_ram_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ram_arbiter_if bus();
  ram_arbiter #(.TIMEOUT(63), .DMA_RUN(4)) dut (.clk_sys(clk), .reset(rst), .bus(bus));

  typedef struct { logic [24:0] addr; logic we; logic [7:0] din; } acc_t;
  typedef struct { logic [2:0] who; logic rd; logic [7:0] data; } ack_t; // who = {ld,dma,cpu}
  typedef struct {
    int who; logic we; logic [24:0] addr; logic [7:0] din; logic [7:0] rdata;
    logic [24:0] e_addr; logic [2:0] e_ack; logic e_we;
  } vec_t;

  acc_t exp_acc[$];
  ack_t exp_ack[$];
  int   n_chk = 0;
  int   n_err = 0;
  logic       resp_en = 1'b1;
  logic [7:0] resp_data = 8'h00;
  logic       resp_pend = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic push_acc(input logic [24:0] a, input logic we, input logic [7:0] d);
    acc_t e;
    e.addr = a; e.we = we; e.din = d;
    exp_acc.push_back(e);
  endtask

  task automatic push_ack(input logic [2:0] who, input logic rd, input logic [7:0] d);
    ack_t e;
    e.who = who; e.rd = rd; e.data = d;
    exp_ack.push_back(e);
  endtask

  task automatic wait_ack(input string nm, input int bound, output int lat);
    lat = -1;
    for (int k = 1; k <= bound; k++) begin
      tick();
      if (bus.ld_ack | bus.dma_ack | bus.cpu_ack) begin lat = k; break; end
    end
    if (lat < 0) begin
      n_chk++; n_err++;
      $display("FAIL %s: no ack within %0d cycles", nm, bound);
    end
  endtask

  // RAM controller model: answers one cycle after each strobe
  initial forever begin
    @(posedge clk); #1;
    if (resp_en) begin
      bus.mem_ready = resp_pend;
      bus.mem_dout  = resp_pend ? resp_data : 8'h00;
      resp_pend     = bus.mem_rd | bus.mem_we;
    end else
      resp_pend = 1'b0;
  end

  // scoreboard: every strobe and every ack must match the head of its queue
  initial begin
    acc_t ea;
    ack_t ek;
    forever begin
      @(posedge clk); #1;
      if (!rst) begin
        if (bus.mem_we | bus.mem_rd) begin
          chk("strobe_both", {31'b0, bus.mem_we & bus.mem_rd}, 0);
          if (exp_acc.size() == 0) begin
            n_chk++; n_err++;
            $display("FAIL unexpected_access: addr %0h we %0b", bus.mem_addr, bus.mem_we);
          end else begin
            ea = exp_acc.pop_front();
            chk("acc_addr", bus.mem_addr, ea.addr);
            chk("acc_we", bus.mem_we, ea.we);
            if (ea.we) chk("acc_din", bus.mem_din, ea.din);
          end
        end
        if ({bus.ld_ack, bus.dma_ack, bus.cpu_ack} != 3'b000) begin
          if (exp_ack.size() == 0) begin
            n_chk++; n_err++;
            $display("FAIL unexpected_ack: acks %03b", {bus.ld_ack, bus.dma_ack, bus.cpu_ack});
          end else begin
            ek = exp_ack.pop_front();
            chk("ack_who", {bus.ld_ack, bus.dma_ack, bus.cpu_ack}, ek.who);
            if (ek.rd) chk("ack_data", ek.who[1] ? bus.dma_data : bus.cpu_dout, ek.data);
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    n_chk++; n_err++;
    $display("FAIL watchdog: simulation did not complete");
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  task automatic drop_all();
    bus.ld_req = 1'b0; bus.dma_req = 1'b0; bus.cpu_req = 1'b0;
  endtask

  task automatic apply(input vec_t v, input int idx);
    int lat;
    resp_data = v.rdata;
    push_acc(v.e_addr, v.e_we, v.din);
    push_ack(v.e_ack, !v.e_we, v.rdata);
    case (v.who)
      0:       begin bus.ld_addr = v.addr; bus.ld_data = v.din; bus.ld_req = 1'b1; end
      1:       begin bus.dma_addr = v.addr[15:0]; bus.dma_req = 1'b1; end
      default: begin bus.cpu_addr = v.addr; bus.cpu_din = v.din; bus.cpu_we = v.we; bus.cpu_req = 1'b1; end
    endcase
    wait_ack($sformatf("vec%0d_ack", idx), 20, lat);
    chk($sformatf("vec%0d_latency", idx), lat, 3);
    tick();       // stale req still up during the IDLE after DONE
    drop_all();
    tick(3);
  endtask

  vec_t vt[6];
  int   lat, nacks, cnt, ld_n, dma_n, cpu_n;
  logic [2:0] drop_nxt;

  initial begin
    // who, we, addr, din, rdata | expected mem_addr, ack, we
    vt[0] = '{2, 1'b0, 25'h00ABCD,  8'h00, 8'h5A, 25'h00ABCD,  3'b001, 1'b0};
    vt[1] = '{2, 1'b1, 25'h1FFFFFF, 8'hA5, 8'h00, 25'h1FFFFFF, 3'b001, 1'b1};
    vt[2] = '{0, 1'b1, 25'h1234567, 8'h11, 8'h00, 25'h1234567, 3'b100, 1'b1};
    vt[3] = '{1, 1'b0, 25'h000BEEF, 8'h00, 8'hC3, 25'h000BEEF, 3'b010, 1'b0};
    vt[4] = '{1, 1'b0, 25'h000FFFF, 8'h00, 8'h3C, 25'h000FFFF, 3'b010, 1'b0};
    vt[5] = '{2, 1'b0, 25'h0000000, 8'h00, 8'hFF, 25'h0000000, 3'b001, 1'b0};

    drop_all();
    bus.ld_addr = 25'h1555555; bus.ld_data = 8'h00; bus.dma_addr = 16'h0;
    bus.cpu_we = 1'b0; bus.cpu_addr = 25'h0; bus.cpu_din = 8'h00;
    bus.mem_ready = 1'b0; bus.mem_dout = 8'h00;

    // reset state
    rst = 1'b1;
    tick(3);
    chk("rst_busy", bus.busy, 0);
    chk("rst_acks", {bus.ld_ack, bus.dma_ack, bus.cpu_ack}, 0);
    chk("rst_strobes", {bus.mem_we, bus.mem_rd}, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_mem_din", bus.mem_din, 0);
    chk("rst_dma_data", bus.dma_data, 0);
    chk("rst_cpu_dout", bus.cpu_dout, 0);
    chk("rst_terr", bus.timeout_err, 0);
    rst = 1'b0;
    tick();

    // mem_ready in IDLE is ignored
    resp_en = 1'b0;
    bus.mem_ready = 1'b1; bus.mem_dout = 8'hEE;
    tick();
    bus.mem_ready = 1'b0;
    tick(2);
    chk("idle_ready_busy", bus.busy, 0);
    chk("idle_ready_cpu_dout", bus.cpu_dout, 0);
    chk("idle_ready_dma_data", bus.dma_data, 0);
    resp_en = 1'b1;

    for (int i = 0; i < 6; i++) apply(vt[i], i);

    // priority: all three at once
    resp_data = 8'h99;
    bus.ld_addr = 25'h0100000; bus.ld_data = 8'hD7;
    bus.dma_addr = 16'h0200;
    bus.cpu_addr = 25'h0000300; bus.cpu_we = 1'b0;
    push_acc(25'h0100000, 1'b1, 8'hD7);  push_ack(3'b100, 1'b0, 8'h00);
    push_acc(25'h0000200, 1'b0, 8'h00);  push_ack(3'b010, 1'b1, 8'h99);
    push_acc(25'h0000300, 1'b0, 8'h00);  push_ack(3'b001, 1'b1, 8'h99);
    bus.ld_req = 1'b1; bus.dma_req = 1'b1; bus.cpu_req = 1'b1;
    ld_n = 0; dma_n = 0; cpu_n = 0; drop_nxt = 3'b000;
    for (int k = 0; k < 80; k++) begin
      tick();
      if (drop_nxt[2]) bus.ld_req = 1'b0;
      if (drop_nxt[1]) bus.dma_req = 1'b0;
      if (drop_nxt[0]) bus.cpu_req = 1'b0;
      drop_nxt = {bus.ld_ack, bus.dma_ack, bus.cpu_ack};
      ld_n += int'(bus.ld_ack); dma_n += int'(bus.dma_ack); cpu_n += int'(bus.cpu_ack);
    end
    chk("prio_ld_acks", ld_n, 1);
    chk("prio_dma_acks", dma_n, 1);
    chk("prio_cpu_acks", cpu_n, 1);
    chk("prio_drained", exp_ack.size(), 0);

    // DMA run limit: both held, CPU forced in after four DMA grants
    resp_data = 8'h77;
    bus.dma_addr = 16'h0500;
    bus.cpu_addr = 25'h0000400; bus.cpu_we = 1'b1; bus.cpu_din = 8'h5C;
    for (int i = 0; i < 10; i++) begin
      if (i == 4 || i == 9) begin
        push_acc(25'h0000400, 1'b1, 8'h5C); push_ack(3'b001, 1'b0, 8'h00);
      end else begin
        push_acc(25'h0000500, 1'b0, 8'h00); push_ack(3'b010, 1'b1, 8'h77);
      end
    end
    bus.dma_req = 1'b1; bus.cpu_req = 1'b1;
    nacks = 0;
    for (int k = 0; k < 300 && nacks < 10; k++) begin
      tick();
      if (bus.dma_ack | bus.cpu_ack) nacks++;
    end
    drop_all();
    tick(6);
    chk("starve_acks", nacks, 10);
    chk("starve_drained", exp_acc.size() + exp_ack.size(), 0);

    // timeout: CPU read, memory never answers
    resp_en = 1'b0; bus.mem_ready = 1'b0;
    chk("tmo_err_before", bus.timeout_err, 0);
    bus.cpu_addr = 25'h0000600; bus.cpu_we = 1'b0;
    push_acc(25'h0000600, 1'b0, 8'h00); push_ack(3'b001, 1'b1, 8'hFF);
    bus.cpu_req = 1'b1;
    cnt = 0;
    while (!bus.mem_rd && cnt < 5) begin tick(); cnt++; end
    chk("tmo_issue_seen", bus.mem_rd, 1);
    wait_ack("tmo_ack", 100, lat);
    chk("tmo_latency", lat, 64);
    chk("tmo_cpu_dout", bus.cpu_dout, 8'hFF);
    chk("tmo_err", bus.timeout_err, 1);
    tick();
    drop_all();
    tick(2);
    bus.mem_ready = 1'b1; bus.mem_dout = 8'h12;
    tick();
    bus.mem_ready = 1'b0;
    tick(3);
    chk("late_ready_busy", bus.busy, 0);
    chk("late_ready_cpu_dout", bus.cpu_dout, 8'hFF);
    chk("late_ready_err", bus.timeout_err, 1);

    // reset while in WAIT
    bus.cpu_addr = 25'h0000700; bus.cpu_we = 1'b0;
    push_acc(25'h0000700, 1'b0, 8'h00);
    bus.cpu_req = 1'b1;
    tick(6);
    chk("mid_busy", bus.busy, 1);
    rst = 1'b1; bus.cpu_req = 1'b0;
    tick();
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_acks", {bus.ld_ack, bus.dma_ack, bus.cpu_ack}, 0);
    chk("mid_rst_mem_addr", bus.mem_addr, 0);
    chk("mid_rst_cpu_dout", bus.cpu_dout, 0);
    chk("mid_rst_err", bus.timeout_err, 0);
    rst = 1'b0;
    tick(4);
    chk("mid_no_ack", exp_acc.size() + exp_ack.size(), 0);

    resp_en = 1'b1;
    bus.cpu_addr = 25'h0000001; bus.cpu_we = 1'b1; bus.cpu_din = 8'h3C;
    push_acc(25'h0000001, 1'b1, 8'h3C); push_ack(3'b001, 1'b0, 8'h00);
    bus.cpu_req = 1'b1;
    wait_ack("post_rst_ack", 20, lat);
    chk("post_rst_latency", lat, 3);
    tick();
    drop_all();
    tick(4);
    chk("final_drained", exp_acc.size() + exp_ack.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
